// File: rtl/fft_ctrl_pkg.sv
// Shared state encoding, default geometry and scale-schedule width for fft_ctrl.
package fft_ctrl_pkg;

  localparam int unsigned NFFT_DEF = 2048;
  localparam int unsigned IW_DEF   = 11;
  localparam int unsigned DW_DEF   = 10;
  localparam int unsigned SCALE_W  = 12;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    START,
    LOAD,
    PROC,
    UNLOAD,
    FIN
  } state_t;

endpackage

// File: rtl/fft_ctrl_wdog.sv
// Frame watchdog: counts busy cycles since the last accept and flags the cycle the limit is reached.
module fft_ctrl_wdog #(
  parameter int unsigned WDOG_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic hit
);

  localparam int unsigned CW = $clog2(WDOG_CYC + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the busy cycles already completed, so the current one is the WDOG_CYC-th.
  assign hit = active && (cnt == CW'(WDOG_CYC - 1));

endmodule

// File: rtl/fft_ctrl.sv
// Sequences one frame through a streaming FFT core: configure, start, load, wait, unload.
// Define FFT_CTRL_WDOG_EN to add a busy-cycle watchdog (fft_ctrl_wdog) that aborts stuck frames.
module fft_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned NFFT     = NFFT_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned IW       = IW_DEF,
  parameter int unsigned WDOG_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               req_inv,
  input  logic [SCALE_W-1:0] req_scale,
  output logic               ack,
  output logic               busy,
  output logic [IW-1:0]      buf_addr,
  input  logic [DW-1:0]      buf_re,
  input  logic [DW-1:0]      buf_im,
  output logic               fft_start,
  output logic               fft_fwd_inv,
  output logic               fft_fwd_inv_we,
  output logic               fft_scale_sch_we,
  output logic [SCALE_W-1:0] fft_scale_sch,
  output logic [DW-1:0]      fft_xn_re,
  output logic [DW-1:0]      fft_xn_im,
  input  logic               fft_rfd,
  input  logic               fft_busy,
  input  logic               fft_done,
  input  logic               fft_dv,
  input  logic [IW-1:0]      fft_xn_index,
  input  logic [IW-1:0]      fft_xk_index,
  input  logic [DW-1:0]      fft_xk_re,
  input  logic [DW-1:0]      fft_xk_im,
  output logic               res_valid,
  output logic [IW-1:0]      res_index,
  output logic [DW-1:0]      res_re,
  output logic [DW-1:0]      res_im,
  output logic               frame_done,
  output logic               err
);

  if (NFFT > (64'd1 << IW)) begin : g_bad_nfft
    $error("fft_ctrl: NFFT does not fit in IW index bits");
  end
  if (WDOG_CYC == 0) begin : g_bad_wdog
    $error("fft_ctrl: WDOG_CYC must be at least 1");
  end

  state_t               state, state_nxt;
  logic                 inv_reg;
  logic [SCALE_W-1:0]   scale_reg;
  logic [IW:0]          load_cnt;
  logic [IW-1:0]        out_cnt;
  logic                 rfd_q;
  logic                 accept, rfd_fall, load_err, unload_last, wdog_hit;

  // The core has no reset, so an accept also needs it idle; a reset cycle never accepts.
  assign accept      = (state == IDLE) && req && !fft_busy && !fft_rfd && !rst;
  assign rfd_fall    = (state == LOAD) && rfd_q && !fft_rfd;
  assign load_err    = rfd_fall && (load_cnt != (IW+1)'(NFFT));
  assign unload_last = (state == UNLOAD) && fft_dv && (out_cnt == IW'(NFFT - 1));

`ifdef FFT_CTRL_WDOG_EN
  fft_ctrl_wdog #(
    .WDOG_CYC (WDOG_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .active (busy),
    .hit    (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      inv_reg   <= 1'b0;
      scale_reg <= '0;
      load_cnt  <= '0;
      out_cnt   <= '0;
      rfd_q     <= 1'b0;
      res_valid <= 1'b0;
      res_index <= '0;
      res_re    <= '0;
      res_im    <= '0;
    end else begin
      state <= state_nxt;
      rfd_q <= fft_rfd;

      if (accept) begin
        inv_reg   <= req_inv;
        scale_reg <= req_scale;
        load_cnt  <= '0;
      end else if ((state == LOAD) && fft_rfd) begin
        load_cnt <= load_cnt + 1'b1;
      end

      // Result port is a one-cycle-late copy of the core output, zeroed outside UNLOAD.
      if (state == UNLOAD) begin
        res_valid <= fft_dv;
        res_index <= fft_xk_index;
        res_re    <= fft_xk_re;
        res_im    <= fft_xk_im;
        if (fft_dv) begin
          out_cnt <= unload_last ? '0 : out_cnt + 1'b1;
        end
      end else begin
        res_valid <= 1'b0;
        res_index <= '0;
        res_re    <= '0;
        res_im    <= '0;
        out_cnt   <= '0;
      end
    end
  end

  // NOTE: next state defaults to the current one before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CFG;
      CFG:     state_nxt = START;
      START:   state_nxt = LOAD;
      LOAD:    if (rfd_fall) state_nxt = load_err ? IDLE : PROC;
      PROC:    if (fft_done) state_nxt = UNLOAD;
      UNLOAD:  if (unload_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (wdog_hit) state_nxt = IDLE;
  end

  assign ack              = accept;
  assign busy             = (state != IDLE);
  assign fft_fwd_inv_we   = (state == CFG);
  assign fft_scale_sch_we = (state == CFG);
  assign fft_fwd_inv      = (state == CFG) && !inv_reg;
  assign fft_scale_sch    = (state == CFG) ? scale_reg : '0;
  assign fft_start        = (state == START) && !wdog_hit;
  assign buf_addr         = (state == LOAD) ? fft_xn_index : '0;
  assign fft_xn_re        = (state == LOAD) ? buf_re : '0;
  assign fft_xn_im        = (state == LOAD) ? buf_im : '0;
  assign frame_done       = (state == FIN);
  assign err              = load_err || wdog_hit;

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: scripted core model, random buffer/result data, queue-based result model.
module tb_fft_ctrl;

  localparam int NFFT = 2048;
  localparam int DW   = 10;
  localparam int IW   = 11;
  localparam int WDOG = 5000;

  logic          clk = 1'b0;
  logic          rst, req, req_inv;
  logic [11:0]   req_scale;
  logic          ack, busy;
  logic [IW-1:0] buf_addr;
  logic [DW-1:0] buf_re, buf_im;
  logic          fft_start, fft_fwd_inv, fft_fwd_inv_we, fft_scale_sch_we;
  logic [11:0]   fft_scale_sch;
  logic [DW-1:0] fft_xn_re, fft_xn_im;
  logic          fft_rfd, fft_busy, fft_done, fft_dv;
  logic [IW-1:0] fft_xn_index, fft_xk_index;
  logic [DW-1:0] fft_xk_re, fft_xk_im;
  logic          res_valid;
  logic [IW-1:0] res_index;
  logic [DW-1:0] res_re, res_im;
  logic          frame_done, err;

  fft_ctrl #(
    .NFFT     (NFFT),
    .DW       (DW),
    .IW       (IW),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_inv          (req_inv),
    .req_scale        (req_scale),
    .ack              (ack),
    .busy             (busy),
    .buf_addr         (buf_addr),
    .buf_re           (buf_re),
    .buf_im           (buf_im),
    .fft_start        (fft_start),
    .fft_fwd_inv      (fft_fwd_inv),
    .fft_fwd_inv_we   (fft_fwd_inv_we),
    .fft_scale_sch_we (fft_scale_sch_we),
    .fft_scale_sch    (fft_scale_sch),
    .fft_xn_re        (fft_xn_re),
    .fft_xn_im        (fft_xn_im),
    .fft_rfd          (fft_rfd),
    .fft_busy         (fft_busy),
    .fft_done         (fft_done),
    .fft_dv           (fft_dv),
    .fft_xn_index     (fft_xn_index),
    .fft_xk_index     (fft_xk_index),
    .fft_xk_re        (fft_xk_re),
    .fft_xk_im        (fft_xk_im),
    .res_valid        (res_valid),
    .res_index        (res_index),
    .res_re           (res_re),
    .res_im           (res_im),
    .frame_done       (frame_done),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Sample buffer: real part is the address, imaginary part a random table, read asynchronously.
  logic [DW-1:0] im_mem [NFFT];
  assign buf_re = buf_addr[DW-1:0];
  assign buf_im = im_mem[buf_addr];

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int          fd_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } beat_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Request, then check the configuration strobe and the start pulse; returns in the first LOAD cycle.
  task automatic accept_seq(input logic inv, input logic [11:0] sc, input bit hold);
    req = 1'b1; req_inv = inv; req_scale = sc;
    sample();
    check("ack", ack, 1);
    check("ack_busy_low", busy, 0);
    acc_cyc = cyc;
    step();
    if (!hold) req = 1'b0;
    req_inv = !inv; req_scale = ~sc;
    sample();
    check("cfg_we", {fft_fwd_inv_we, fft_scale_sch_we}, 2'b11);
    check("cfg_fwd_inv", fft_fwd_inv, !inv);
    check("cfg_scale", fft_scale_sch, sc);
    check("cfg_ack_low", ack, 0);
    check("cfg_start_low", fft_start, 0);
    check("cfg_busy", busy, 1);
    step();
    sample();
    check("start", fft_start, 1);
    check("start_we_low", {fft_fwd_inv_we, fft_scale_sch_we}, 0);
    step();
  endtask

  task automatic load_phase(input int n, output bit aborted);
    fft_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      fft_rfd = 1'b1;
      fft_xn_index = IW'(i);
      sample();
      check("xn_addr", buf_addr, i);
      check("xn_re", fft_xn_re, i % 1024);
      check("xn_im", fft_xn_im, im_mem[i]);
      step();
    end
    fft_rfd = 1'b0;
    sample();
    check("load_err", err, n != NFFT);
    check("load_busy", busy, 1);
    step();
    aborted = (n != NFFT);
    if (aborted) begin
      fft_busy = 1'b0;
      sample();
      check("abort_idle", busy, 0);
      check("abort_err_once", err, 0);
      check("abort_no_done", frame_done, 0);
      step();
    end
  endtask

  task automatic proc_phase(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      if (k == 0) begin
        check("proc_addr_zero", buf_addr, 0);
        check("proc_xn_zero", {fft_xn_re, fft_xn_im}, 0);
        check("proc_res_idle", res_valid, 0);
      end
      check("proc_busy", busy, 1);
      step();
    end
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
  endtask

  task automatic unload_phase(input int rst_at);
    beat_t q[$];
    beat_t b, e;
    bit    dv;
    bit    last_dv = 1'b0;
    int    k = 0;
    int    n_valid = 0;
    while (k < NFFT) begin
      if (k == rst_at) begin
        rst = 1'b1; req = 1'b1; fft_dv = 1'b1;
        sample();
        step();
        sample();
        check("rst_ctl_zero", {ack, busy, fft_start, fft_fwd_inv, fft_fwd_inv_we,
                               fft_scale_sch_we, res_valid, frame_done, err}, 0);
        check("rst_addr_zero", buf_addr, 0);
        check("rst_scale_zero", fft_scale_sch, 0);
        check("rst_xn_zero", {fft_xn_re, fft_xn_im}, 0);
        check("rst_res_zero", {res_index, res_re}, 0);
        check("rst_res_im_zero", res_im, 0);
        return;
      end
      dv = ($urandom_range(0, 7) != 0);
      b.idx = IW'(k);
      b.re  = DW'($urandom);
      b.im  = DW'($urandom);
      fft_dv = dv;
      fft_xk_index = dv ? b.idx : IW'($urandom);
      fft_xk_re = b.re;
      fft_xk_im = b.im;
      if (dv) begin
        q.push_back(b);
        k++;
      end
      sample();
      check("res_valid", res_valid, last_dv);
      if (last_dv) begin
        e = q.pop_front();
        check("res_index", res_index, e.idx);
        check("res_re", res_re, e.re);
        check("res_im", res_im, e.im);
      end
      if (res_valid === 1'b1) n_valid++;
      check("unload_no_done", frame_done, 0);
      last_dv = dv;
      step();
    end
    fft_dv = 1'b0;
    fft_busy = 1'b0;
    sample();
    check("fin_res_valid", res_valid, 1);
    if (res_valid === 1'b1) n_valid++;
    e = q.pop_front();
    check("fin_res_index", res_index, e.idx);
    check("fin_res_data", {res_re, res_im}, {e.re, e.im});
    check("frame_done", frame_done, 1);
    check("fin_busy", busy, 1);
    check("fin_ack_low", ack, 0);
    check("res_beats", n_valid, NFFT);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "tb_fft_ctrl timeout");
  end

  initial begin
    bit aborted;
    rst = 1'b1; req = 1'b0; req_inv = 1'b0; req_scale = '0;
    fft_rfd = 1'b0; fft_busy = 1'b0; fft_done = 1'b0; fft_dv = 1'b0;
    fft_xn_index = '0; fft_xk_index = '0; fft_xk_re = '0; fft_xk_im = '0;
    for (int i = 0; i < NFFT; i++) im_mem[i] = DW'($urandom);

    repeat (3) step();
    sample();
    check("reset_ctl", {ack, busy, fft_start, fft_fwd_inv_we, fft_scale_sch_we,
                        res_valid, frame_done, err}, 0);
    step();
    rst = 1'b0;

    // Forward frame, fixed scale schedule, full load and unload.
    accept_seq(1'b0, 12'hAAA, 1'b0);
    load_phase(NFFT, aborted);
    proc_phase($urandom_range(1, 20));
    unload_phase(-1);
    sample();
    check("idle_after_fin", busy, 0);
    check("frames_1", fd_cnt, 1);
    step();

    // Core stops taking samples early: error pulse, back to idle, no frame_done.
    accept_seq(1'($urandom), 12'($urandom), 1'b0);
    load_phase(2000, aborted);
    check("frames_after_short", fd_cnt, 1);

    // Reset mid-unload, then the core stays busy while req is held.
    accept_seq(1'b1, 12'($urandom), 1'b0);
    load_phase(NFFT, aborted);
    proc_phase($urandom_range(1, 20));
    unload_phase(1000);
    step();
    rst = 1'b0; req = 1'b1; fft_busy = 1'b1; fft_dv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample();
      check("ack_wait_busy", ack, 0);
      step();
    end
    fft_busy = 1'b0;
    check("frames_after_rst", fd_cnt, 1);

    // Two frames with req held throughout: second ack lands the cycle after frame_done.
    accept_seq(1'b0, 12'($urandom), 1'b1);
    load_phase(NFFT, aborted);
    proc_phase($urandom_range(1, 20));
    unload_phase(-1);
    accept_seq(1'b1, 12'($urandom), 1'b1);
    load_phase(NFFT, aborted);
    proc_phase($urandom_range(1, 20));
    unload_phase(-1);
    req = 1'b0;
    sample();
    check("final_idle", {busy, ack}, 0);
    check("frames_total", fd_cnt, 3);
    step();

`ifdef FFT_CTRL_WDOG_EN
    // Core never reports done: watchdog error on the WDOG-th busy cycle after accept.
    accept_seq(1'b0, 12'($urandom), 1'b0);
    load_phase(NFFT, aborted);
    fft_busy = 1'b1;
    for (int c = 0; c < WDOG + 1000; c++) begin
      sample();
      if (err === 1'b1) break;
      step();
    end
    check("wdog_err_cycle", cyc - acc_cyc, WDOG);
    step();
    sample();
    check("wdog_idle", {busy, fft_start}, 0);
    fft_busy = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
